// File: rtl/uart_pkg.sv
// uart_pkg: shared baud constants, divider helpers and FSM state encodings for uart
package uart_pkg;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 115_200;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = OVERSAMPLE / 2;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int rx_tick_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
  localparam int DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);
  localparam int DEF_RX_DIV = rx_tick_div(DEF_CLK_FREQ, DEF_BAUD);
endpackage

// File: rtl/uart_baud_rate_gen.sv
// baud_rate_gen: TX bit-period tick and free-running RX 16x oversample tick
//   clk_i, rst_i : clock, synchronous active-high reset
//   tx_en_i      : high while a TX frame runs; low holds the bit counter at zero
//   tx_tick_o    : one-cycle pulse on the last cycle of each TX bit
//   rx_tick_o    : one-cycle pulse every RX_DIV cycles
module baud_rate_gen import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int RX_DIV = DEF_RX_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tx_en_i,
  output logic tx_tick_o,
  output logic rx_tick_o
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int RW = $clog2(RX_DIV + 1);
  logic [TW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RW-1:0] rx_cnt_q, rx_cnt_d;
  // The TX counter idles at zero so a new frame's start bit lasts a full period.
  always_comb begin
    tx_tick_o = tx_en_i && tx_cnt_q == TW'(CLKS_PER_BIT - 1);
    rx_tick_o = rx_cnt_q == RW'(RX_DIV - 1);
    tx_cnt_d = (!tx_en_i || tx_tick_o) ? '0 : tx_cnt_q + TW'(1);
    rx_cnt_d = rx_tick_o ? '0 : rx_cnt_q + RW'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end
endmodule

// File: rtl/uart.sv
// uart: 8N1 transmitter and 16x-oversampling receiver with independent FSMs
//   clk_50m, rst        : clock, synchronous active-high reset
//   data_in, wr_en      : byte to send and one-cycle send request (ignored while Tx_busy)
//   Tx, Tx_busy         : serial output (idle high) and frame-in-progress flag
//   Rx                  : asynchronous serial input (idle high)
//   ready, ready_clr    : received-byte flag and its clear (a new byte wins over clear)
//   data_out            : last correctly framed received byte
module uart import uart_pkg::*; #(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       Tx,
  output logic       Tx_busy,
  input  logic       Rx,
  output logic       ready,
  input  logic       ready_clr,
  output logic [7:0] data_out
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int RXD = rx_tick_div(CLK_FREQ, BAUD);
  tx_state_e tx_state_q, tx_state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [1:0] sync_q;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] data_out_q, data_out_d;
  logic ready_q, ready_d, rx_set, rx_s, tx_tick, rx_tick;
  baud_rate_gen #(.CLKS_PER_BIT(CPB), .RX_DIV(RXD)) u_baud (
    .clk_i(clk_50m),
    .rst_i(rst),
    .tx_en_i(Tx_busy),
    .tx_tick_o(tx_tick),
    .rx_tick_o(rx_tick)
  );
  assign rx_s = sync_q[1];
  assign Tx_busy = tx_state_q != TX_IDLE;
  assign Tx = tx_state_q == TX_START ? 1'b0 : tx_state_q == TX_DATA ? tx_data_q[tx_bit_q] : 1'b1;
  assign ready = ready_q;
  assign data_out = data_out_q;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d = tx_data_q;
    tx_bit_d = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: if (wr_en) begin
        tx_state_d = TX_START;
        tx_data_d = data_in;
        tx_bit_d = '0;
      end
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA: if (tx_tick) begin
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
    endcase
  end
  // rx_cnt_q counts oversample ticks within the current bit; the start bit is
  // confirmed at its midpoint and every later sample lands one bit further on.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out_q;
    rx_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_s) begin
        rx_state_d = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: if (rx_tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'(MID_SAMPLE - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'(OVERSAMPLE - 1)) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'(OVERSAMPLE - 1)) begin
          rx_state_d = RX_IDLE;
          rx_set = rx_s;
          if (rx_s) data_out_d = rx_shift_q;
        end
      end
    endcase
    ready_d = rx_set | (ready_q & ~ready_clr);
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_data_q <= '0;
      tx_bit_q <= '0;
      rx_state_q <= RX_IDLE;
      sync_q <= 2'b11;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      data_out_q <= '0;
      ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q <= tx_data_d;
      tx_bit_q <= tx_bit_d;
      rx_state_q <= rx_state_d;
      sync_q <= {sync_q[0], Rx};
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: tb/tb_uart.sv
// tb_uart: randomized loopback and line-level scenarios against a frame-level model
module tb_uart;
  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD = 100_000;
  localparam int CPB = CLK_FREQ / BAUD;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, ready_clr = 1'b0, loop = 1'b1, rx_drv = 1'b1;
  logic [7:0] data_in = '0;
  logic tx, tx_busy, ready, rx_line;
  logic [7:0] data_out;
  logic [7:0] exp_dout = '0;
  int checks = 0, failures = 0;
  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_50m(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .Tx(tx), .Tx_busy(tx_busy),
    .Rx(rx_line), .ready(ready), .ready_clr(ready_clr), .data_out(data_out)
  );
  // Sends one byte through the transmitter and observes a 12-bit-period window:
  // contiguous busy length, Tx at each bit midpoint, and the first ready.
  task automatic xfer(input logic [7:0] b, input bit inject, input logic [7:0] junk,
                      output int busy_n, output logic [9:0] line, output bit got,
                      output logic [7:0] dout, output int rdy_n);
    busy_n = 0; line = '0; got = 0; dout = '0; rdy_n = -1;
    @(negedge clk); data_in = b; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    for (int n = 0; n < 12 * CPB; n++) begin
      if (tx_busy && busy_n == n) busy_n++;
      if (n % CPB == CPB / 2 && n < 10 * CPB) line[n / CPB] = tx;
      if (ready && !got) begin got = 1; dout = data_out; rdy_n = n; end
      if (inject && n == 5 * CPB) begin data_in = junk; wr_en = 1'b1; end
      if (inject && n == 5 * CPB + 1) wr_en = 1'b0;
      @(negedge clk);
    end
  endtask
  // Drives a frame directly on Rx; a bad frame holds the stop bit low past its midpoint.
  task automatic drive_frame(input logic [7:0] b, input bit good, output bit got, output logic [7:0] dout);
    int k;
    got = 0; dout = '0; loop = 1'b0;
    for (int n = 0; n < 14 * CPB; n++) begin
      k = n / CPB;
      rx_drv = k == 0 ? 1'b0 : k < 9 ? b[k-1] : k == 9 ? (good || n % CPB >= 3 * CPB / 4) : 1'b1;
      @(negedge clk);
      if (ready && !got) begin got = 1; dout = data_out; end
    end
    rx_drv = 1'b1; loop = 1'b1;
  endtask
  task automatic pulse_clr();
    @(negedge clk); ready_clr = 1'b1;
    @(negedge clk); ready_clr = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    rst = 1'b0;
    exp_dout = '0;
  endtask
  task automatic test_loopback();
    int busy_n, rdy_n; logic [9:0] line; bit got; logic [7:0] dout;
    xfer(8'h03, 0, 8'h00, busy_n, line, got, dout, rdy_n);
    checks++; if (busy_n !== 10 * CPB) begin failures++; $display("FAIL loop_busy_len got=%0d exp=%0d", busy_n, 10 * CPB); end
    checks++; if (line !== {1'b1, 8'h03, 1'b0}) begin failures++; $display("FAIL loop_line got=%b exp=%b", line, {1'b1, 8'h03, 1'b0}); end
    checks++; if (!got || dout !== 8'h03) begin failures++; $display("FAIL loop_data got=%0d/%h exp=1/03", got, dout); end
    checks++; if (rdy_n < 9 * CPB || rdy_n > 11 * CPB) begin failures++; $display("FAIL loop_ready_time got=%0d exp=%0d..%0d", rdy_n, 9 * CPB, 11 * CPB); end
    exp_dout = 8'h03;
    pulse_clr();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL loop_clr got=%b exp=0", ready); end
  endtask
  task automatic test_sweep();
    int busy_n, rdy_n; logic [9:0] line; bit got; logic [7:0] dout, b;
    for (int i = 0; i < 42; i++) begin
      b = i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'($urandom_range(0, 255));
      xfer(b, 0, 8'h00, busy_n, line, got, dout, rdy_n);
      checks++; if (line !== {1'b1, b, 1'b0}) begin failures++; $display("FAIL sweep_line[%0d] got=%b exp=%b", i, line, {1'b1, b, 1'b0}); end
      checks++; if (!got || dout !== b) begin failures++; $display("FAIL sweep_data[%0d] got=%0d/%h exp=1/%h", i, got, dout, b); end
      exp_dout = b;
      pulse_clr();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL sweep_clr[%0d] got=%b exp=0", i, ready); end
    end
  endtask
  task automatic test_busy();
    int busy_n, rdy_n; logic [9:0] line; bit got; logic [7:0] dout; bit late;
    xfer(8'h55, 1, 8'hAA, busy_n, line, got, dout, rdy_n);
    checks++; if (busy_n !== 10 * CPB) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", busy_n, 10 * CPB); end
    checks++; if (line !== {1'b1, 8'h55, 1'b0}) begin failures++; $display("FAIL busy_line got=%b exp=%b", line, {1'b1, 8'h55, 1'b0}); end
    checks++; if (!got || dout !== 8'h55) begin failures++; $display("FAIL busy_data got=%0d/%h exp=1/55", got, dout); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL busy_after got=%b exp=0", tx_busy); end
    exp_dout = 8'h55;
    pulse_clr();
    late = 0;
    for (int n = 0; n < 12 * CPB; n++) begin @(negedge clk); if (ready) late = 1; end
    checks++; if (late !== 1'b0) begin failures++; $display("FAIL busy_second_byte got=%0d exp=0", late); end
  endtask
  task automatic test_glitch();
    bit seen = 0;
    loop = 1'b0;
    @(negedge clk); rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    for (int n = 0; n < 12 * CPB; n++) begin @(negedge clk); if (ready) seen = 1; end
    loop = 1'b1;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_ready got=%0d exp=0", seen); end
    checks++; if (data_out !== exp_dout) begin failures++; $display("FAIL glitch_dout got=%h exp=%h", data_out, exp_dout); end
  endtask
  task automatic test_framing();
    bit got; logic [7:0] dout;
    drive_frame(8'hC3, 0, got, dout);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL frame_err_ready got=%0d exp=0", got); end
    checks++; if (data_out !== exp_dout) begin failures++; $display("FAIL frame_err_dout got=%h exp=%h", data_out, exp_dout); end
    drive_frame(8'h5A, 1, got, dout);
    checks++; if (!got || dout !== 8'h5A) begin failures++; $display("FAIL frame_good got=%0d/%h exp=1/5a", got, dout); end
    exp_dout = 8'h5A;
    pulse_clr();
  endtask
  task automatic test_collision();
    int busy_n, rdy_n; logic [9:0] line; bit got; logic [7:0] dout;
    ready_clr = 1'b1;
    xfer(8'h3C, 0, 8'h00, busy_n, line, got, dout, rdy_n);
    checks++; if (!got || dout !== 8'h3C) begin failures++; $display("FAIL collision_set got=%0d/%h exp=1/3c", got, dout); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL collision_clear_after got=%b exp=0", ready); end
    ready_clr = 1'b0;
    exp_dout = 8'h3C;
  endtask
  task automatic test_reset_midframe();
    int busy_n, rdy_n; logic [9:0] line; bit got, seen; logic [7:0] dout;
    @(negedge clk); data_in = 8'hA5; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    repeat (3 * CPB + 5) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", tx_busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_tx got=%b/%b exp=1/0", tx, tx_busy); end
    checks++; if (ready !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL mid_rst_rx got=%b/%h exp=0/00", ready, data_out); end
    rst = 1'b0;
    exp_dout = '0;
    seen = 0;
    for (int n = 0; n < 12 * CPB; n++) begin @(negedge clk); if (ready || tx_busy) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_aborted got=%0d exp=0", seen); end
    xfer(8'h81, 0, 8'h00, busy_n, line, got, dout, rdy_n);
    checks++; if (!got || dout !== 8'h81) begin failures++; $display("FAIL mid_recover got=%0d/%h exp=1/81", got, dout); end
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_sweep();
    test_busy();
    test_glitch();
    test_framing();
    test_collision();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
